// File: rtl/t05_pkg.sv
// rtl/t05_pkg.sv - shared types and constants for the find-least scanner
package t05_pkg;

  localparam int NUM_ENTRIES = 256;
  localparam int ADDR_W      = 8;
  localparam int CNT_W       = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CMP,
    DONE
  } find_least_state_t;

  // Unsigned add that clamps to CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/t05_least_cmp.sv
// rtl/t05_least_cmp.sv - combinational insert of one (addr,cnt) into the smallest pair
module t05_least_cmp
  import t05_pkg::*;
#(
  parameter int ADDR_W = t05_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic [1:0]        found_in,
  input  logic [ADDR_W-1:0] l1_addr_in,
  input  logic [CNT_W-1:0]  l1_cnt_in,
  input  logic [ADDR_W-1:0] l2_addr_in,
  input  logic [CNT_W-1:0]  l2_cnt_in,
  output logic [ADDR_W-1:0] l1_addr_out,
  output logic [CNT_W-1:0]  l1_cnt_out,
  output logic [ADDR_W-1:0] l2_addr_out,
  output logic [CNT_W-1:0]  l2_cnt_out,
  output logic [1:0]        found_out
);

  // Empty slots (tracked by found_in) act as +infinity so an all-ones count
  // still lands; strict < keeps the earlier (lower) address on ties.
  always_comb begin
    l1_addr_out = l1_addr_in;
    l1_cnt_out  = l1_cnt_in;
    l2_addr_out = l2_addr_in;
    l2_cnt_out  = l2_cnt_in;
    found_out   = found_in;
    if (in_cnt != '0) begin
      if (found_in != 2'd2) found_out = found_in + 2'd1;
      if (found_in == 2'd0 || in_cnt < l1_cnt_in) begin
        l2_addr_out = l1_addr_in;
        l2_cnt_out  = l1_cnt_in;
        l1_addr_out = in_addr;
        l1_cnt_out  = in_cnt;
      end else if (found_in == 2'd1 || in_cnt < l2_cnt_in) begin
        l2_addr_out = in_addr;
        l2_cnt_out  = in_cnt;
      end
    end
  end

endmodule

// File: rtl/t05_find_least.sv
// rtl/t05_find_least.sv - scans the frequency SRAM for the two smallest nonzero counts
module t05_find_least
  import t05_pkg::*;
#(
  parameter int NUM_ENTRIES = t05_pkg::NUM_ENTRIES,
  parameter int ADDR_W      = t05_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] least1_addr,
  output logic [31:0]       least1_cnt,
  output logic [ADDR_W-1:0] least2_addr,
  output logic [31:0]       least2_cnt,
  output logic [31:0]       sum_cnt,
  output logic [1:0]        found_cnt,
  output logic              pair_valid
);

  find_least_state_t state, state_nxt;

  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt_q;
  logic              last;

  logic [ADDR_W-1:0] l1_addr_n, l2_addr_n;
  logic [CNT_W-1:0]  l1_cnt_n, l2_cnt_n;
  logic [1:0]        found_n;

  assign last       = (idx == ADDR_W'(NUM_ENTRIES - 1));
  assign rd_req     = (state == REQ);
  assign rd_addr    = idx;
  assign busy       = (state == REQ) || (state == WAIT) || (state == CMP);
  assign done       = (state == DONE);
  assign pair_valid = (found_cnt == 2'd2);

  t05_least_cmp #(.ADDR_W(ADDR_W)) u_cmp (
    .in_addr     (idx),
    .in_cnt      (cnt_q),
    .found_in    (found_cnt),
    .l1_addr_in  (least1_addr),
    .l1_cnt_in   (least1_cnt),
    .l2_addr_in  (least2_addr),
    .l2_cnt_in   (least2_cnt),
    .l1_addr_out (l1_addr_n),
    .l1_cnt_out  (l1_cnt_n),
    .l2_addr_out (l2_addr_n),
    .l2_cnt_out  (l2_cnt_n),
    .found_out   (found_n)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE, rd_valid only in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (rd_valid) state_nxt = CMP;
      CMP:     state_nxt = last ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index, captured read data and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      cnt_q       <= '0;
      least1_addr <= '0;
      least1_cnt  <= CNT_MAX;
      least2_addr <= '0;
      least2_cnt  <= CNT_MAX;
      sum_cnt     <= '0;
      found_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx         <= '0;
          least1_addr <= '0;
          least1_cnt  <= CNT_MAX;
          least2_addr <= '0;
          least2_cnt  <= CNT_MAX;
          sum_cnt     <= '0;
          found_cnt   <= '0;
        end
        WAIT: if (rd_valid) cnt_q <= rd_data;
        CMP: begin
          least1_addr <= l1_addr_n;
          least1_cnt  <= l1_cnt_n;
          least2_addr <= l2_addr_n;
          least2_cnt  <= l2_cnt_n;
          found_cnt   <= found_n;
          // Sum is loaded on entry to DONE so it is valid alongside done.
          if (last) sum_cnt <= (found_n == 2'd2) ? sat_add(l1_cnt_n, l2_cnt_n) : '0;
          else      idx     <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_find_least.sv
// tb/tb_t05_find_least.sv - directed self-checking bench for t05_find_least
module tb_t05_find_least;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy, done, pair_valid;
  logic [7:0]  least1_addr, least2_addr;
  logic [31:0] least1_cnt, least2_cnt, sum_cnt;
  logic [1:0]  found_cnt;

  logic [31:0] mem [256];
  int lat = 1;
  int ctr = 0;
  int n_checks = 0;
  int n_fail = 0;
  int req_cnt, seq_err, stab_err, done_cnt;
  logic [7:0] exp_addr, held_addr;
  int cyc;

  always #5 clk = ~clk;

  t05_find_least dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done),
    .least1_addr(least1_addr), .least1_cnt(least1_cnt),
    .least2_addr(least2_addr), .least2_cnt(least2_cnt),
    .sum_cnt(sum_cnt), .found_cnt(found_cnt), .pair_valid(pair_valid)
  );

  // SRAM model: acknowledge lat cycles after the request, garbage otherwise.
  always @(posedge clk or negedge rst) begin
    if (!rst)             ctr <= 0;
    else if (rd_req)      ctr <= lat;
    else if (ctr != 0)    ctr <= ctr - 1;
  end
  assign rd_valid = (ctr == 1);
  assign rd_data  = rd_valid ? mem[rd_addr] : 32'hDEAD_BEEF;

  // Read-port observer: address sequence, address hold, done pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_req) begin
        if (rd_addr != exp_addr) seq_err++;
        exp_addr++;
        held_addr = rd_addr;
        req_cnt++;
      end else if (ctr != 0 && rd_addr != held_addr) begin
        stab_err++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic load_case1();
    clear_mem();
    mem[65] = 32'd2;
    mem[66] = 32'd1;
    mem[67] = 32'd1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_rd_req"},  {31'd0, rd_req}, 32'd0);
    check_eq({pfx, "_rd_addr"}, {24'd0, rd_addr}, 32'd0);
    check_eq({pfx, "_busy"},    {31'd0, busy}, 32'd0);
    check_eq({pfx, "_done"},    {31'd0, done}, 32'd0);
    check_eq({pfx, "_l1_addr"}, {24'd0, least1_addr}, 32'd0);
    check_eq({pfx, "_l1_cnt"},  least1_cnt, 32'hFFFF_FFFF);
    check_eq({pfx, "_l2_addr"}, {24'd0, least2_addr}, 32'd0);
    check_eq({pfx, "_l2_cnt"},  least2_cnt, 32'hFFFF_FFFF);
    check_eq({pfx, "_sum"},     sum_cnt, 32'd0);
    check_eq({pfx, "_found"},   {30'd0, found_cnt}, 32'd0);
    check_eq({pfx, "_pair"},    {31'd0, pair_valid}, 32'd0);
  endtask

  // Pulse start, count edges until done, optionally re-pulse start mid-scan.
  task automatic run_scan(input string tag, input int mid_at);
    bit got;
    bit busy1;
    req_cnt = 0; seq_err = 0; stab_err = 0; done_cnt = 0; exp_addr = 8'd0;
    got = 1'b0;
    busy1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (cyc < 3000 && !got) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1 || cyc == mid_at + 1) start = 1'b0;
      if (cyc == mid_at) start = 1'b1;
      if (cyc == 1) busy1 = busy;
      if (done) begin
        got = 1'b1;
        check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check_eq({tag, "_busy_after_start"}, {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_one_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_done_count"}, done_cnt, 32'd1);
    check_eq({tag, "_req_count"}, req_cnt, 32'd256);
    check_eq({tag, "_addr_seq"}, seq_err, 32'd0);
  endtask

  initial begin
    bit hit;
    clear_mem();
    #2 rst = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Case 1: two tied ones beat the two at 65.
    load_case1();
    run_scan("c1", 0);
    check_eq("c1_latency", cyc, 32'd769);
    check_eq("c1_l1_addr", {24'd0, least1_addr}, 32'd66);
    check_eq("c1_l1_cnt",  least1_cnt, 32'd1);
    check_eq("c1_l2_addr", {24'd0, least2_addr}, 32'd67);
    check_eq("c1_l2_cnt",  least2_cnt, 32'd1);
    check_eq("c1_sum",     sum_cnt, 32'd2);
    check_eq("c1_found",   {30'd0, found_cnt}, 32'd2);
    check_eq("c1_pair",    {31'd0, pair_valid}, 32'd1);

    // Case 2: empty histogram.
    clear_mem();
    run_scan("c2", 0);
    check_eq("c2_found", {30'd0, found_cnt}, 32'd0);
    check_eq("c2_pair",  {31'd0, pair_valid}, 32'd0);
    check_eq("c2_sum",   sum_cnt, 32'd0);
    check_eq("c2_l1_cnt", least1_cnt, 32'hFFFF_FFFF);

    // Case 3: single nonzero entry at the top address.
    clear_mem();
    mem[255] = 32'd7;
    run_scan("c3", 0);
    check_eq("c3_found",   {30'd0, found_cnt}, 32'd1);
    check_eq("c3_l1_addr", {24'd0, least1_addr}, 32'd255);
    check_eq("c3_l1_cnt",  least1_cnt, 32'd7);
    check_eq("c3_l2_cnt",  least2_cnt, 32'hFFFF_FFFF);
    check_eq("c3_pair",    {31'd0, pair_valid}, 32'd0);
    check_eq("c3_sum",     sum_cnt, 32'd0);

    // Case 4: three-way tie resolves to the lowest addresses.
    clear_mem();
    mem[10] = 32'd5; mem[20] = 32'd5; mem[30] = 32'd5; mem[40] = 32'd9;
    run_scan("c4", 0);
    check_eq("c4_l1_addr", {24'd0, least1_addr}, 32'd10);
    check_eq("c4_l1_cnt",  least1_cnt, 32'd5);
    check_eq("c4_l2_addr", {24'd0, least2_addr}, 32'd20);
    check_eq("c4_l2_cnt",  least2_cnt, 32'd5);
    check_eq("c4_sum",     sum_cnt, 32'd10);

    // Case 5: reset at entry 100 mid-scan, then a clean rerun on case-1 data.
    load_case1();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (rd_req && rd_addr == 8'd100) hit = 1'b1;
    end
    check_eq("c5_reached_entry100", {31'd0, hit}, 32'd1);
    rst = 1'b0;
    #1 check_reset_vals("c5_abort");
    @(negedge clk);
    rst = 1'b1;
    run_scan("c5", 0);
    check_eq("c5_l1_addr", {24'd0, least1_addr}, 32'd66);
    check_eq("c5_l2_addr", {24'd0, least2_addr}, 32'd67);
    check_eq("c5_sum",     sum_cnt, 32'd2);

    // Case 6: slow SRAM, all-ones counts, spurious start mid-scan.
    clear_mem();
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = 32'hFFFF_FFFF;
    lat = 3;
    run_scan("c6", 500);
    check_eq("c6_latency",   cyc, 32'd1281);
    check_eq("c6_addr_hold", stab_err, 32'd0);
    check_eq("c6_l1_addr",   {24'd0, least1_addr}, 32'd0);
    check_eq("c6_l2_addr",   {24'd0, least2_addr}, 32'd1);
    check_eq("c6_sum_sat",   sum_cnt, 32'hFFFF_FFFF);
    check_eq("c6_pair",      {31'd0, pair_valid}, 32'd1);
    @(negedge clk);
    check_eq("c6_idle_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
